// File: rtl/intra_border_buf.sv
// Neighbour-pixel source for the intra predictors: captures reconstructed blocks
// (bottom row into a per-column line buffer, right column into a left register) and serves top/left vectors.
module intra_border_buf #(
    parameter int BIT_WIDTH  = 8,
    parameter int BLOCK_SIZE = 16,
    parameter int BLOCK_NUM  = 10,
    parameter int ADDR_W     = 6
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [BLOCK_NUM-1:0]            x,
    input  logic [BLOCK_NUM-1:0]            y,
    output logic [BIT_WIDTH*BLOCK_SIZE-1:0] top,
    output logic [BIT_WIDTH*BLOCK_SIZE-1:0] left,
    output logic                            top_avail,
    output logic                            left_avail,
    output logic                            done,
    input  logic                            wr_start,
    input  logic [BLOCK_NUM-1:0]            wr_x,
    input  logic                            row_valid,
    input  logic [BIT_WIDTH*BLOCK_SIZE-1:0] row_data,
    output logic                            wr_busy,
    output logic                            wr_done
);
    localparam int ROW_W = BIT_WIDTH * BLOCK_SIZE;
    localparam int CNT_W = $clog2(BLOCK_SIZE) + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ROW_W-1:0] TOP_FILL  = {BLOCK_SIZE{BIT_WIDTH'(127)}};
    localparam logic [ROW_W-1:0] LEFT_FILL = {BLOCK_SIZE{BIT_WIDTH'(129)}};

    typedef enum logic [2:0] {R_IDLE = 3'b001, R_READ = 3'b010, R_DONE = 3'b100} r_state_t;
    typedef enum logic [2:0] {W_IDLE = 3'b001, W_CAP = 3'b010, W_COMMIT = 3'b100} w_state_t;

    r_state_t r_state_reg, r_state_next;
    w_state_t w_state_reg, w_state_next;

    logic [BLOCK_NUM-1:0] x_reg, y_reg;
    logic [ROW_W-1:0]     top_reg, left_out_reg, left_reg, ram_q_reg, shadow_packed;
    logic                 top_avail_reg, left_avail_reg;
    logic [ADDR_W-1:0]    wr_addr_reg;
    logic [CNT_W-1:0]     row_cnt_reg;
    logic                 wr_busy_reg;
    logic [BIT_WIDTH-1:0] shadow_reg [BLOCK_SIZE];
    logic [ROW_W-1:0]     line_ram [DEPTH];
    logic                 rd_en, wr_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_reg <= R_IDLE;
            w_state_reg <= W_IDLE;
        end else begin
            r_state_reg <= r_state_next;
            w_state_reg <= w_state_next;
        end
    end

    always_comb begin
        r_state_next = r_state_reg;
        rd_en        = 1'b0;
        case (r_state_reg)
            R_IDLE: begin
                rd_en = start;
                if (start) r_state_next = R_READ;
            end
            R_READ:  r_state_next = R_DONE;
            R_DONE:  r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_next = w_state_reg;
        wr_last      = 1'b0;
        case (w_state_reg)
            W_IDLE: if (wr_start) w_state_next = W_CAP;
            W_CAP: begin
                wr_last = row_valid && (row_cnt_reg == CNT_W'(BLOCK_SIZE - 1));
                if (wr_last) w_state_next = W_COMMIT;
            end
            W_COMMIT: w_state_next = W_IDLE;
            default:  w_state_next = W_IDLE;
        endcase
    end

    // Registered-read line buffer; a same-address read and write returns the old word
    always_ff @(posedge clk) begin
        if (wr_last) line_ram[wr_addr_reg] <= row_data;
        if (rd_en)   ram_q_reg <= line_ram[x[ADDR_W-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg          <= '0;
            y_reg          <= '0;
            top_reg        <= '0;
            left_out_reg   <= '0;
            top_avail_reg  <= 1'b0;
            left_avail_reg <= 1'b0;
        end else begin
            if (rd_en) begin
                x_reg <= x;
                y_reg <= y;
            end
            if (r_state_reg == R_READ) begin
                top_reg        <= (y_reg != '0) ? ram_q_reg : TOP_FILL;
                left_out_reg   <= (x_reg != '0) ? left_reg : LEFT_FILL;
                top_avail_reg  <= (y_reg != '0);
                left_avail_reg <= (x_reg != '0);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_shadow_pack
            assign shadow_packed[BIT_WIDTH*gi +: BIT_WIDTH] = shadow_reg[gi];
        end
    endgenerate

    // Shadow collects the right-most pixel of each row; the left register only changes on commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_reg <= '0;
            row_cnt_reg <= '0;
            wr_busy_reg <= 1'b0;
            left_reg    <= '0;
            for (int i = 0; i < BLOCK_SIZE; i++) shadow_reg[i] <= '0;
        end else begin
            case (w_state_reg)
                W_IDLE: if (wr_start) begin
                    wr_addr_reg <= wr_x[ADDR_W-1:0];
                    row_cnt_reg <= '0;
                    wr_busy_reg <= 1'b1;
                end
                W_CAP: if (row_valid) begin
                    shadow_reg[row_cnt_reg[CNT_W-2:0]] <= row_data[ROW_W-1 -: BIT_WIDTH];
                    row_cnt_reg <= row_cnt_reg + 1'b1;
                end
                W_COMMIT: begin
                    left_reg    <= shadow_packed;
                    wr_busy_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign top        = top_reg;
    assign left       = left_out_reg;
    assign top_avail  = top_avail_reg;
    assign left_avail = left_avail_reg;
    assign done       = (r_state_reg == R_DONE);
    assign wr_busy    = wr_busy_reg;
    assign wr_done    = (w_state_reg == W_COMMIT);
endmodule
